// File: rtl/adc_sample_packer_pkg.sv
// Shared definitions for the ADC sample packer: data widths, default
// parameter values, the high-byte header nibble and the serializer states.
package adc_sample_packer_pkg;

   localparam int unsigned DATA_W       = 12;
   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned DEF_AVG_LOG2 = 2;
   localparam int unsigned DEF_FIFO_AW  = 4;

   // Marks the high byte of every word so a receiver can resynchronise.
   localparam logic [3:0] HDR_NIBBLE = 4'hA;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_HI = 2'd1,
      SEND_LO = 2'd2
   } ser_state_t;

   // Layout of the first byte sent for each word.
   typedef struct packed {
      logic [3:0] hdr;
      logic [3:0] nib;
   } hi_byte_t;

   // Builds the header-tagged high byte of a 12-bit word.
   function automatic logic [BYTE_W-1:0] hi_byte(input logic [DATA_W-1:0] word);
      hi_byte_t b;
      b.hdr = HDR_NIBBLE;
      b.nib = word[11:8];
      return b;
   endfunction

endpackage

// File: rtl/adc_sample_packer_if.sv
// Bundle of the sample input, UART byte output and status signals of the
// ADC sample packer.
//   slave  : the packer (consumes samples and tx_ready, drives bytes/status)
//   master : the environment (drives samples and tx_ready)
//   sample_valid/sample_data : XADC conversion strobe and 12-bit result
//   tx_data/tx_valid/tx_ready: byte stream to the UART transmitter
//   fifo_level/overflow/drop_count : buffering status
interface adc_sample_packer_if #(
   parameter int unsigned FIFO_AW = adc_sample_packer_pkg::DEF_FIFO_AW
);
   logic                                      sample_valid;
   logic [adc_sample_packer_pkg::DATA_W-1:0]  sample_data;
   logic [adc_sample_packer_pkg::BYTE_W-1:0]  tx_data;
   logic                                      tx_valid;
   logic                                      tx_ready;
   logic [FIFO_AW:0]                          fifo_level;
   logic                                      overflow;
   logic [7:0]                                drop_count;

   modport slave (
      input  sample_valid, sample_data, tx_ready,
      output tx_data, tx_valid, fifo_level, overflow, drop_count
   );

   modport master (
      output sample_valid, sample_data, tx_ready,
      input  tx_data, tx_valid, fifo_level, overflow, drop_count
   );
endinterface

// File: rtl/adc_sample_packer_sync_fifo.sv
// Synchronous FIFO holding averaged words between averager and serializer.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push/i_wdata : write request; accepted only when not full
//   i_pop/o_rdata  : head word (show-ahead) and pop request; ignored when empty
//   o_full/o_empty/o_level : occupancy status
module sync_fifo #(
   parameter int unsigned DW = 12,
   parameter int unsigned AW = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_pop,
   output logic [DW-1:0] o_rdata,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_level
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_push_ok;
   logic          w_pop_ok;

   // Fullness is judged before any same-edge pop, so a full FIFO drops the write.
   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;

   // Storage array; contents need no reset because pointers gate reads.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally at DEPTH; level tracks net push/pop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/adc_sample_packer.sv
// Averages 2^AVG_LOG2 XADC samples into 12-bit words, buffers them in a FIFO
// and serialises each word to the UART as two bytes: {A, word[11:8]} then
// word[7:0].
//   CLK104MHZ : sole clock
//   rst       : synchronous active-high reset
//   bus       : sample input, tx byte handshake and FIFO/drop status
module adc_sample_packer
   import adc_sample_packer_pkg::*;
#(
   parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2,
   parameter int unsigned FIFO_AW  = DEF_FIFO_AW
) (
   input  logic                CLK104MHZ,
   input  logic                rst,
   adc_sample_packer_if.slave  bus
);

   localparam int unsigned ACC_W   = DATA_W + AVG_LOG2;
   localparam int unsigned CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int unsigned WIN_LEN = 1 << AVG_LOG2;

   // ---------------- averager ----------------
   logic [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_avg_word;
   logic              r_avg_valid;
   logic [ACC_W-1:0]  w_sum;
   logic              w_last;
   logic [DATA_W-1:0] w_avg;

   assign w_sum  = r_acc + ACC_W'(bus.sample_data);
   // With no averaging every sample closes its own window.
   assign w_last = (AVG_LOG2 == 0) ? 1'b1 : (r_cnt == CNT_W'(WIN_LEN - 1));
   assign w_avg  = DATA_W'(w_sum >> AVG_LOG2);

   // Accumulate one window; emit the truncated mean as a one-cycle strobe.
   always_ff @(posedge CLK104MHZ) begin
      if (rst) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_avg_word  <= '0;
         r_avg_valid <= 1'b0;
      end else begin
         r_avg_valid <= 1'b0;
         if (bus.sample_valid) begin
            if (w_last) begin
               r_acc       <= '0;
               r_cnt       <= '0;
               r_avg_word  <= w_avg;
               r_avg_valid <= 1'b1;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   // ---------------- FIFO ----------------
   logic [DATA_W-1:0] w_head;
   logic              w_full;
   logic              w_empty;
   logic [FIFO_AW:0]  w_level;
   logic              w_pop;
   logic              w_drop;

   sync_fifo #(
      .DW (DATA_W),
      .AW (FIFO_AW)
   ) u_fifo (
      .i_clk   (CLK104MHZ),
      .i_rst   (rst),
      .i_push  (r_avg_valid),
      .i_wdata (r_avg_word),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign w_drop = r_avg_valid & w_full;

   // ---------------- drop accounting ----------------
   logic       r_overflow;
   logic [7:0] r_drop_count;

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge CLK104MHZ) begin
      if (rst) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_count != 8'hFF) begin
            r_drop_count <= r_drop_count + 8'd1;
         end
      end
   end

   // ---------------- serializer ----------------
   ser_state_t        r_state;
   ser_state_t        w_state_n;
   logic [DATA_W-1:0] r_word;
   logic [DATA_W-1:0] w_word_n;
   logic [BYTE_W-1:0] r_tx_data;
   logic [BYTE_W-1:0] w_tx_data_n;
   logic              r_tx_valid;
   logic              w_tx_valid_n;

   // State, held word and output byte registers.
   always_ff @(posedge CLK104MHZ) begin
      if (rst) begin
         r_state    <= IDLE;
         r_word     <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_word     <= w_word_n;
         r_tx_data  <= w_tx_data_n;
         r_tx_valid <= w_tx_valid_n;
      end
   end

   // Next state; the next byte is prepared so tx_data/tx_valid come from flops.
   always_comb begin
      w_state_n    = r_state;
      w_word_n     = r_word;
      w_tx_data_n  = r_tx_data;
      w_tx_valid_n = r_tx_valid;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_word_n     = w_head;
               w_tx_data_n  = hi_byte(w_head);
               w_tx_valid_n = 1'b1;
               w_state_n    = SEND_HI;
            end
         end
         SEND_HI: begin
            if (bus.tx_ready) begin
               w_tx_data_n = r_word[7:0];
               w_state_n   = SEND_LO;
            end
         end
         SEND_LO: begin
            if (bus.tx_ready) begin
               // Chain straight into the next word to avoid an idle gap.
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_word_n     = w_head;
                  w_tx_data_n  = hi_byte(w_head);
                  w_tx_valid_n = 1'b1;
                  w_state_n    = SEND_HI;
               end else begin
                  w_tx_data_n  = '0;
                  w_tx_valid_n = 1'b0;
                  w_state_n    = IDLE;
               end
            end
         end
         default: begin
            w_tx_data_n  = '0;
            w_tx_valid_n = 1'b0;
            w_state_n    = IDLE;
         end
      endcase
   end

   assign bus.tx_data    = r_tx_data;
   assign bus.tx_valid   = r_tx_valid;
   assign bus.fifo_level = w_level;
   assign bus.overflow   = r_overflow;
   assign bus.drop_count = r_drop_count;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Bench for adc_sample_packer: one instance averaging over 4 samples and one
// pass-through instance, both with a 16-word FIFO. Expected bytes go into a
// queue per instance and are popped when the DUT completes a byte handshake.
module tb_adc_sample_packer;

   logic clk;
   logic rst;

   adc_sample_packer_if #(.FIFO_AW(4)) bus_a ();
   adc_sample_packer_if #(.FIFO_AW(4)) bus_p ();

   adc_sample_packer #(.AVG_LOG2(2), .FIFO_AW(4)) u_dut_avg (
      .CLK104MHZ (clk),
      .rst       (rst),
      .bus       (bus_a)
   );

   adc_sample_packer #(.AVG_LOG2(0), .FIFO_AW(4)) u_dut_pass (
      .CLK104MHZ (clk),
      .rst       (rst),
      .bus       (bus_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] s0;
      logic [11:0] s1;
      logic [11:0] s2;
      logic [11:0] s3;
      logic [11:0] w;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   logic [7:0] exp_a [$];
   logic [7:0] exp_p [$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic push_word_a(input logic [11:0] w);
      exp_a.push_back({4'hA, w[11:8]});
      exp_a.push_back(w[7:0]);
   endtask

   task automatic push_word_p(input logic [11:0] w);
      exp_p.push_back({4'hA, w[11:8]});
      exp_p.push_back(w[7:0]);
   endtask

   // One clock: scoreboard at the falling edge, return 1ns after the rising edge.
   task automatic tick();
      logic [7:0] b;
      @(negedge clk);
      if (!rst) begin
         if (bus_a.tx_valid && bus_a.tx_ready) begin
            if (exp_a.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL avg_unexpected_byte: actual=0x%0h required=none", bus_a.tx_data);
            end else begin
               b = exp_a.pop_front();
               check("avg_byte", 32'(bus_a.tx_data), 32'(b));
            end
         end
         if (bus_p.tx_valid && bus_p.tx_ready) begin
            if (exp_p.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL pass_unexpected_byte: actual=0x%0h required=none", bus_p.tx_data);
            end else begin
               b = exp_p.pop_front();
               check("pass_byte", 32'(bus_p.tx_data), 32'(b));
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Let both serializers run until every expected byte is out, bounded.
   task automatic drain(input int budget);
      int n;
      n = 0;
      bus_a.tx_ready = 1'b1;
      bus_p.tx_ready = 1'b1;
      while ((exp_a.size() != 0 || exp_p.size() != 0 || bus_a.tx_valid || bus_p.tx_valid)
             && n < budget) begin
         tick();
         n++;
      end
      check("drain_pending_bytes", 32'(exp_a.size() + exp_p.size()), 32'd0);
   endtask

   initial begin
      logic [11:0] smp [4];
      int n;

      vecs[0] = '{12'd100,  12'd101,  12'd102,  12'd105,  12'd102};
      vecs[1] = '{12'd0,    12'd0,    12'd0,    12'd0,    12'd0};
      vecs[2] = '{12'hFFF,  12'hFFF,  12'hFFF,  12'hFFF,  12'hFFF};
      vecs[3] = '{12'd1,    12'd1,    12'd1,    12'd0,    12'd0};
      vecs[4] = '{12'd7,    12'd0,    12'd0,    12'd0,    12'd1};
      vecs[5] = '{12'hFFF,  12'hFFF,  12'hFFF,  12'hFFE,  12'hFFE};
      vecs[6] = '{12'h800,  12'h000,  12'h000,  12'h000,  12'h200};
      vecs[7] = '{12'h123,  12'h456,  12'h789,  12'hABC,  12'h5EF};

      // Reset with strobes active: they must be ignored.
      rst                = 1'b1;
      bus_a.sample_valid = 1'b1;
      bus_a.sample_data  = 12'h123;
      bus_a.tx_ready     = 1'b0;
      bus_p.sample_valid = 1'b1;
      bus_p.sample_data  = 12'h123;
      bus_p.tx_ready     = 1'b0;
      repeat (3) tick();
      rst                = 1'b0;
      bus_a.sample_valid = 1'b0;
      bus_p.sample_valid = 1'b0;

      check("rst_avg_tx_valid",  32'(bus_a.tx_valid),   32'd0);
      check("rst_avg_tx_data",   32'(bus_a.tx_data),    32'd0);
      check("rst_avg_level",     32'(bus_a.fifo_level), 32'd0);
      check("rst_avg_overflow",  32'(bus_a.overflow),   32'd0);
      check("rst_avg_drops",     32'(bus_a.drop_count), 32'd0);
      check("rst_pass_tx_valid", 32'(bus_p.tx_valid),   32'd0);
      check("rst_pass_tx_data",  32'(bus_p.tx_data),    32'd0);
      check("rst_pass_level",    32'(bus_p.fifo_level), 32'd0);
      check("rst_pass_overflow", 32'(bus_p.overflow),   32'd0);
      check("rst_pass_drops",    32'(bus_p.drop_count), 32'd0);
      repeat (4) tick();
      check("pass_ignores_rst_samples_level", 32'(bus_p.fifo_level), 32'd0);
      check("pass_ignores_rst_samples_valid", 32'(bus_p.tx_valid),   32'd0);

      // Averaging table, words back to back with the UART always ready.
      bus_a.tx_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         push_word_a(vecs[i].w);
         smp[0] = vecs[i].s0;
         smp[1] = vecs[i].s1;
         smp[2] = vecs[i].s2;
         smp[3] = vecs[i].s3;
         for (int j = 0; j < 4; j++) begin
            bus_a.sample_valid = 1'b1;
            bus_a.sample_data  = smp[j];
            tick();
            bus_a.sample_valid = 1'b0;
            bus_a.sample_data  = 12'hFFF;
            if (j == 1) tick();
         end
      end
      drain(200);
      check("avg_level_after_table", 32'(bus_a.fifo_level), 32'd0);
      check("avg_overflow_clear",    32'(bus_a.overflow),   32'd0);
      check("avg_no_drops",          32'(bus_a.drop_count), 32'd0);

      // Reset mid-window discards the partial sum.
      bus_a.sample_valid = 1'b1;
      bus_a.sample_data  = 12'd1000;
      repeat (2) tick();
      bus_a.sample_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("avg_midwin_rst_valid", 32'(bus_a.tx_valid),   32'd0);
      check("avg_midwin_rst_level", 32'(bus_a.fifo_level), 32'd0);
      push_word_a(12'd8);
      bus_a.sample_valid = 1'b1;
      bus_a.sample_data  = 12'd8;
      repeat (4) tick();
      bus_a.sample_valid = 1'b0;
      drain(50);

      // Pass-through word held under back-pressure.
      bus_p.tx_ready     = 1'b0;
      bus_p.sample_valid = 1'b1;
      bus_p.sample_data  = 12'hFFF;
      tick();
      bus_p.sample_valid = 1'b0;
      n = 0;
      while (!bus_p.tx_valid && n < 10) begin
         tick();
         n++;
      end
      check("pass_first_byte_latency", 32'(n), 32'd2);
      for (int k = 0; k < 10; k++) begin
         tick();
         check("pass_stall_tx_data",  32'(bus_p.tx_data),  32'hAF);
         check("pass_stall_tx_valid", 32'(bus_p.tx_valid), 32'd1);
      end
      push_word_p(12'hFFF);
      drain(20);
      check("pass_idle_tx_valid", 32'(bus_p.tx_valid), 32'd0);
      check("pass_idle_tx_data",  32'(bus_p.tx_data),  32'd0);

      // 20 samples into a stalled pipe: 1 held, 16 buffered, 3 dropped.
      bus_p.tx_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus_p.sample_valid = 1'b1;
         bus_p.sample_data  = 12'(12'h100 + i);
         if (i <= 16) push_word_p(12'(12'h100 + i));
         tick();
      end
      bus_p.sample_valid = 1'b0;
      repeat (3) tick();
      check("fill_level",    32'(bus_p.fifo_level), 32'd16);
      check("fill_overflow", 32'(bus_p.overflow),   32'd1);
      check("fill_drops",    32'(bus_p.drop_count), 32'd3);
      check("fill_tx_data",  32'(bus_p.tx_data),    32'hA1);
      check("fill_tx_valid", 32'(bus_p.tx_valid),   32'd1);

      // Write lands on the same edge as a pop from a full FIFO: still dropped.
      bus_p.sample_valid = 1'b1;
      bus_p.sample_data  = 12'h555;
      bus_p.tx_ready     = 1'b1;
      tick();
      bus_p.sample_valid = 1'b0;
      tick();
      bus_p.tx_ready = 1'b0;
      check("coincide_level", 32'(bus_p.fifo_level), 32'd15);
      check("coincide_drops", 32'(bus_p.drop_count), 32'd4);
      tick();
      check("coincide_next_hi", 32'(bus_p.tx_data), 32'hA1);

      // 300 more samples: one fills the last slot, the rest saturate the counter.
      for (int i = 0; i < 300; i++) begin
         bus_p.sample_valid = 1'b1;
         bus_p.sample_data  = 12'(12'h300 + i);
         if (i == 0) push_word_p(12'h300);
         tick();
      end
      bus_p.sample_valid = 1'b0;
      repeat (2) tick();
      check("sat_drops", 32'(bus_p.drop_count), 32'd255);
      check("sat_level", 32'(bus_p.fifo_level), 32'd16);
      drain(300);
      check("final_level",    32'(bus_p.fifo_level), 32'd0);
      check("final_tx_valid", 32'(bus_p.tx_valid),   32'd0);
      check("final_overflow", 32'(bus_p.overflow),   32'd1);
      check("final_drops",    32'(bus_p.drop_count), 32'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adc_sample_packer.md
ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

Interface
REQ-001 Parameter AVG_LOG2, default 2, log2 of samples averaged per output word; legal range 0..4.
REQ-002 Parameter FIFO_AW, default 4, FIFO address width; depth = 2^FIFO_AW words of 12 bits.
REQ-003 CLK104MHZ  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 sample_valid  in  1  one-cycle strobe from the XADC wrapper's data-ready output; marks sample_data valid.
REQ-006 sample_data  in  12  unsigned XADC conversion result.
REQ-007 tx_data  out  8  byte to UART transmitter.
REQ-008 tx_valid  out  1  tx_data holds a byte to send.
REQ-009 tx_ready  in  1  UART transmitter accepts the byte on this edge when tx_valid is high.
REQ-010 fifo_level  out  FIFO_AW+1  number of words currently stored.
REQ-011 overflow  out  1  sticky; set when any averaged word is dropped.
REQ-012 drop_count  out  8  saturating count of dropped words.

Function
REQ-013 Each sample_valid edge adds sample_data to a (12+AVG_LOG2)-bit accumulator and increments a window counter.
REQ-014 On the 2^AVG_LOG2-th sample, the accumulator and counter clear, and sum >> AVG_LOG2 (truncating) registers as the averaged word, flagged valid one cycle.
REQ-015 The averaged word is written to the FIFO on the edge after the last sample of its window (write latency 1).
REQ-016 AVG_LOG2=0: every sample passes through unaveraged with the same 1-cycle latency.
REQ-017 The write is accepted if the FIFO is not full at that edge, regardless of a same-edge pop; otherwise the word is dropped, overflow sets, and drop_count increments, holding at 255.
REQ-018 Same-edge accepted write and pop leave fifo_level unchanged; pointers wrap modulo depth.
REQ-019 Serializer FSM states: IDLE, SEND_HI, SEND_LO.
REQ-020 IDLE: when FIFO is non-empty, pop the head into a holding register and go to SEND_HI; tx_valid is high in the following cycle.
REQ-021 SEND_HI: tx_data = {4'hA, word[11:8]}, tx_valid=1; on tx_ready go to SEND_LO.
REQ-022 SEND_LO: tx_data = word[7:0], tx_valid=1; on tx_ready pop the next word and go to SEND_HI if the FIFO is non-empty, else go to IDLE.
REQ-023 tx_data and tx_valid stay stable while tx_valid=1 and tx_ready=0; tx_valid=0 in IDLE and tx_data=8'h00.
REQ-024 Bytes are never reordered, duplicated or split across words; the header nibble A marks high bytes for resynchronisation.

Reset
REQ-025 While rst=1 at an edge: FSM to IDLE, tx_valid=0, tx_data=0, FIFO pointers and fifo_level=0, accumulator and window counter=0, overflow=0, drop_count=0.
REQ-026 Reset mid-window discards the partial sum; reset mid-word discards the held word without emitting the remaining byte.
REQ-027 sample_valid asserted during reset is ignored.

Structure
REQ-028 A shared package holds the header nibble constant (4'hA), the FSM state enumeration, and the default AVG_LOG2/FIFO_AW values.
REQ-029 The FIFO is a separate sub-module, sync_fifo, with push, pop, full, empty and level; averager and serializer stay in adc_sample_packer.

Verification
REQ-030 AVG_LOG2=2, samples 100,101,102,105, tx_ready=1 -> single word 102 (408>>2); bytes 8'hA0 then 8'h66.
REQ-031 AVG_LOG2=0, sample 12'hFFF, tx_ready held 0 for 10 cycles -> tx_data=8'hAF stable with tx_valid=1; then tx_ready=1 -> 8'hAF, 8'hFF, IDLE.
REQ-032 AVG_LOG2=0, FIFO_AW=4, tx_ready=0, 20 samples -> 1 word held by serializer, fifo_level=16, 3 dropped, overflow=1, drop_count=3.
REQ-033 300 drops with tx_ready=0 -> drop_count stays 255.
REQ-034 rst pulsed after 2 of 4 window samples, then 4 samples of 8 -> output word 8 only (8'hA0, 8'h08).
REQ-035 FIFO full and a write coincides with a serializer pop -> write dropped, fifo_level goes 16 to 15, drop_count +1.
